// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: requester (fetch/load/store) and memory-controller bus around mem_arbiter
interface mem_arbiter_if;
  logic        rdy;
  logic        flush;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_ack;
  logic [31:0] if_data;
  logic        ld_req;
  logic [31:0] ld_addr;
  logic [2:0]  ld_len;
  logic        ld_ack;
  logic [31:0] ld_data;
  logic        st_req;
  logic [31:0] st_addr;
  logic [2:0]  st_len;
  logic [31:0] st_data;
  logic        st_ack;
  logic        mc_req;
  logic        mc_wr;
  logic [31:0] mc_addr;
  logic [2:0]  mc_len;
  logic [31:0] mc_data;
  logic        mc_done;
  logic [31:0] mc_rdata;
  modport slave (
    input  rdy, flush, if_req, if_addr, ld_req, ld_addr, ld_len,
           st_req, st_addr, st_len, st_data, mc_done, mc_rdata,
    output if_ack, if_data, ld_ack, ld_data, st_ack,
           mc_req, mc_wr, mc_addr, mc_len, mc_data
  );
  modport master (
    output rdy, flush, if_req, if_addr, ld_req, ld_addr, ld_len,
           st_req, st_addr, st_len, st_data, mc_done, mc_rdata,
    input  if_ack, if_data, ld_ack, ld_data, st_ack,
           mc_req, mc_wr, mc_addr, mc_len, mc_data
  );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: one-outstanding arbiter (store > load > fetch, fetch starvation guard, flush cancel) onto the memory controller
module mem_arbiter #(
  parameter int STARVE_MAX = 8
) (
  input logic          clk,
  input logic          rst,
  mem_arbiter_if.slave bus
);
  localparam int CW = $clog2(STARVE_MAX + 1);
  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;
  typedef enum logic [1:0] {OWN_IF, OWN_LD, OWN_ST} owner_t;
  state_t        state_q, state_d;
  owner_t        owner_q, owner_d, gnt_own;
  logic [CW-1:0] starve_q, starve_d;
  logic          cancel_q, cancel_d;
  logic          mc_wr_q, mc_wr_d;
  logic [31:0]   mc_addr_q, mc_addr_d;
  logic [2:0]    mc_len_q, mc_len_d;
  logic [31:0]   mc_data_q, mc_data_d;
  logic [31:0]   if_data_q, if_data_d;
  logic [31:0]   ld_data_q, ld_data_d;
  logic          if_v, ld_v, force_if, gnt;
  logic [31:0]   ld_mask;

  // flush hides speculative requesters for the edge it is sampled on
  assign if_v     = bus.if_req & ~bus.flush;
  assign ld_v     = bus.ld_req & ~bus.flush;
  assign force_if = if_v && (starve_q == CW'(STARVE_MAX));
  assign gnt      = bus.st_req | ld_v | if_v;
  assign gnt_own  = force_if ? OWN_IF : bus.st_req ? OWN_ST : ld_v ? OWN_LD : OWN_IF;
  assign ld_mask  = (mc_len_q == 3'd1) ? 32'h0000_00FF :
                    (mc_len_q == 3'd2) ? 32'h0000_FFFF : 32'hFFFF_FFFF;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      owner_q   <= OWN_IF;
      starve_q  <= '0;
      cancel_q  <= 1'b0;
      mc_wr_q   <= 1'b0;
      mc_addr_q <= '0;
      mc_len_q  <= '0;
      mc_data_q <= '0;
      if_data_q <= '0;
      ld_data_q <= '0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      starve_q  <= starve_d;
      cancel_q  <= cancel_d;
      mc_wr_q   <= mc_wr_d;
      mc_addr_q <= mc_addr_d;
      mc_len_q  <= mc_len_d;
      mc_data_q <= mc_data_d;
      if_data_q <= if_data_d;
      ld_data_q <= ld_data_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    starve_d  = starve_q;
    cancel_d  = cancel_q;
    mc_wr_d   = mc_wr_q;
    mc_addr_d = mc_addr_q;
    mc_len_d  = mc_len_q;
    mc_data_d = mc_data_q;
    if_data_d = if_data_q;
    ld_data_d = ld_data_q;
    if (bus.rdy) begin
      if (state_q == IDLE && gnt) begin
        state_d   = BUSY;
        owner_d   = gnt_own;
        mc_wr_d   = gnt_own == OWN_ST;
        mc_addr_d = (gnt_own == OWN_ST) ? bus.st_addr : (gnt_own == OWN_LD) ? bus.ld_addr : bus.if_addr;
        mc_len_d  = (gnt_own == OWN_ST) ? bus.st_len : (gnt_own == OWN_LD) ? bus.ld_len : 3'd4;
        mc_data_d = (gnt_own == OWN_ST) ? bus.st_data : 32'd0;
        starve_d  = (gnt_own == OWN_IF || !bus.if_req) ? '0 :
                    (starve_q == CW'(STARVE_MAX)) ? starve_q : starve_q + CW'(1);
      end else if (state_q == BUSY) begin
        // a cancelled read still completes on the bus but never reaches its owner
        cancel_d = cancel_q | (bus.flush & (owner_q != OWN_ST));
        if (bus.mc_done) begin
          state_d   = RESP;
          if_data_d = (owner_q == OWN_IF && !cancel_d) ? bus.mc_rdata : if_data_q;
          ld_data_d = (owner_q == OWN_LD && !cancel_d) ? (bus.mc_rdata & ld_mask) : ld_data_q;
        end
      end else if (state_q == RESP) begin
        state_d  = IDLE;
        cancel_d = 1'b0;
      end
    end
  end

  always_comb begin
    bus.mc_req = state_q == BUSY;
    bus.if_ack = state_q == RESP && owner_q == OWN_IF && !cancel_q;
    bus.ld_ack = state_q == RESP && owner_q == OWN_LD && !cancel_q;
    bus.st_ack = state_q == RESP && owner_q == OWN_ST;
  end

  assign bus.mc_wr   = mc_wr_q;
  assign bus.mc_addr = mc_addr_q;
  assign bus.mc_len  = mc_len_q;
  assign bus.mc_data = mc_data_q;
  assign bus.if_data = if_data_q;
  assign bus.ld_data = ld_data_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed tests against a transaction-level model of the arbiter
module tb_mem_arbiter;
  localparam int STARVE_MAX = 8;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int checks = 0;
  int failures = 0;

  mem_arbiter_if bus();
  mem_arbiter #(.STARVE_MAX(STARVE_MAX)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a;
    logic [2:0]  l;
    logic [31:0] d;
  } req_t;
  req_t        stq[$];
  req_t        ldq[$];
  logic [31:0] ifq[$];
  int          lat = 1;
  logic        rd_fix_en = 1'b0;
  logic [31:0] rd_fix = 32'd0;
  int          flush_n = 0;
  int          stall_n = 0;
  logic [31:0] glog[$];
  int          gcyc[$];
  int          if_n = 0, ld_n = 0, st_n = 0, cyc = 0;
  logic        prev_req = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  // requesters and memory controller, all inputs driven from this one process
  initial begin : drv
    int wcnt, stall_left, flush_seen, stall_seen;
    wcnt = 0; stall_left = 0; flush_seen = 0; stall_seen = 0;
    bus.rdy = 1'b1; bus.flush = 1'b0;
    bus.if_req = 1'b0; bus.if_addr = '0;
    bus.ld_req = 1'b0; bus.ld_addr = '0; bus.ld_len = '0;
    bus.st_req = 1'b0; bus.st_addr = '0; bus.st_len = '0; bus.st_data = '0;
    bus.mc_done = 1'b0; bus.mc_rdata = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        bus.mc_done = 1'b0; bus.rdy = 1'b1; wcnt = 0; stall_left = 0;
      end else if (stall_left > 0) begin
        stall_left--;
        bus.mc_done  = stall_left == 1;
        bus.mc_rdata = 32'hDEAD_BEEF;
        bus.rdy      = stall_left == 0;
      end else if (bus.mc_done) begin
        bus.mc_done = 1'b0; wcnt = 0;
      end else if (bus.mc_req && stall_seen != stall_n) begin
        stall_seen = stall_n; stall_left = 3; wcnt = 0; bus.rdy = 1'b0;
      end else if (bus.mc_req) begin
        wcnt++;
        if (wcnt >= lat) begin
          bus.mc_done  = 1'b1;
          bus.mc_rdata = rd_fix_en ? rd_fix : {bus.mc_addr[15:0], ~bus.mc_addr[15:0]};
        end
      end
      if (bus.if_ack && ifq.size() > 0) void'(ifq.pop_front());
      if (bus.ld_ack && ldq.size() > 0) void'(ldq.pop_front());
      if (bus.st_ack && stq.size() > 0) void'(stq.pop_front());
      bus.flush = 1'b0;
      if (flush_seen != flush_n) begin
        flush_seen = flush_n; bus.flush = 1'b1; ldq.delete(); ifq.delete();
      end
      bus.if_req  = ifq.size() != 0;
      bus.if_addr = (ifq.size() != 0) ? ifq[0] : 32'd0;
      bus.ld_req  = ldq.size() != 0;
      if (ldq.size() != 0) begin bus.ld_addr = ldq[0].a; bus.ld_len = ldq[0].l; end
      bus.st_req  = stq.size() != 0;
      if (stq.size() != 0) begin bus.st_addr = stq[0].a; bus.st_len = stq[0].l; bus.st_data = stq[0].d; end
    end
  end

  // behavioural model: one transaction at a time, owner 0=fetch 1=load 2=store
  int          m_own = 0, m_starve = 0;
  bit          m_busy = 0, m_resp = 0, m_cancel = 0;
  logic        m_wr = 0;
  logic [2:0]  m_len = 0;
  logic [31:0] m_addr = 0, m_data = 0, m_ifd = 0, m_ldd = 0;

  always @(posedge clk or posedge rst) begin : mdl
    int pick;
    bit f, l;
    if (rst) begin
      m_own = 0; m_starve = 0; m_busy = 0; m_resp = 0; m_cancel = 0;
      m_wr = 0; m_len = 0; m_addr = 0; m_data = 0; m_ifd = 0; m_ldd = 0;
    end else if (bus.rdy) begin
      if (m_resp) begin
        m_resp = 0; m_cancel = 0;
      end else if (m_busy) begin
        if (bus.flush && m_own != 2) m_cancel = 1;
        if (bus.mc_done) begin
          m_busy = 0; m_resp = 1;
          if (!m_cancel && m_own == 0) m_ifd = bus.mc_rdata;
          if (!m_cancel && m_own == 1) m_ldd = 32'(64'(bus.mc_rdata) % (64'd1 << (8 * m_len)));
        end
      end else begin
        f = bus.if_req && !bus.flush;
        l = bus.ld_req && !bus.flush;
        pick = -1;
        if (f && m_starve == STARVE_MAX) pick = 0;
        else if (bus.st_req) pick = 2;
        else if (l) pick = 1;
        else if (f) pick = 0;
        if (pick >= 0) begin
          m_busy = 1; m_own = pick; m_wr = pick == 2;
          m_addr = (pick == 0) ? bus.if_addr : (pick == 1) ? bus.ld_addr : bus.st_addr;
          m_len  = (pick == 0) ? 3'd4 : (pick == 1) ? bus.ld_len : bus.st_len;
          m_data = (pick == 2) ? bus.st_data : 32'd0;
          m_starve = (pick == 0 || !bus.if_req) ? 0 : (m_starve < STARVE_MAX) ? m_starve + 1 : m_starve;
        end
      end
    end
  end

  always @(negedge clk) begin
    cyc++;
    chk("mc_req", bus.mc_req, m_busy);
    chk("mc_wr", bus.mc_wr, m_wr);
    chk("mc_addr", bus.mc_addr, m_addr);
    chk("mc_len", bus.mc_len, m_len);
    chk("mc_data", bus.mc_data, m_data);
    chk("if_ack", bus.if_ack, m_resp && m_own == 0 && !m_cancel);
    chk("ld_ack", bus.ld_ack, m_resp && m_own == 1 && !m_cancel);
    chk("st_ack", bus.st_ack, m_resp && m_own == 2);
    chk("if_data", bus.if_data, m_ifd);
    chk("ld_data", bus.ld_data, m_ldd);
    chk("ack_onehot", ($countones({bus.if_ack, bus.ld_ack, bus.st_ack}) <= 1), 1);
    if_n += int'(bus.if_ack);
    ld_n += int'(bus.ld_ack);
    st_n += int'(bus.st_ack);
    if (bus.mc_req && !prev_req) begin glog.push_back(bus.mc_addr); gcyc.push_back(cyc); end
    prev_req = bus.mc_req;
  end

  task automatic wait_mc(input string nm, input int budget);
    int n = 0;
    while (!bus.mc_req && n < budget) begin @(posedge clk); #2; n++; end
    chk(nm, bus.mc_req, 1);
  endtask

  task automatic drain(input string nm, input int budget);
    int n = 0;
    while ((stq.size() + ldq.size() + ifq.size() != 0 || bus.mc_req || bus.if_ack || bus.ld_ack || bus.st_ack)
           && n < budget) begin
      @(posedge clk); #2; n++;
    end
    chk(nm, n < budget, 1);
    repeat (2) @(posedge clk);
    #2;
  endtask

  initial begin : test
    int b, l0, s0, i0, n;
    #1 rst = 1'b1;
    repeat (3) @(posedge clk);
    #2;
    chk("rst_mc_req", bus.mc_req, 0);
    chk("rst_mc_addr", bus.mc_addr, 0);
    chk("rst_ld_data", bus.ld_data, 0);
    rst = 1'b0;
    // reset in the middle of a store
    lat = 3;
    stq.push_back('{32'h0000_8000, 3'd4, 32'h1111_2222});
    wait_mc("t1_grant", 10);
    @(posedge clk); #2;
    rst = 1'b1; #1;
    chk("t1_rst_mc_req", bus.mc_req, 0);
    chk("t1_rst_mc_wr", bus.mc_wr, 0);
    chk("t1_rst_mc_addr", bus.mc_addr, 0);
    chk("t1_rst_mc_len", bus.mc_len, 0);
    chk("t1_rst_mc_data", bus.mc_data, 0);
    @(posedge clk); #2;
    rst = 1'b0;
    @(posedge clk); #2;
    chk("t1_regrant_req", bus.mc_req, 1);
    chk("t1_regrant_wr", bus.mc_wr, 1);
    chk("t1_regrant_addr", bus.mc_addr, 32'h0000_8000);
    chk("t1_regrant_data", bus.mc_data, 32'h1111_2222);
    drain("t1_drain", 50);
    // single halfword load
    lat = 2; rd_fix_en = 1'b1; rd_fix = 32'hAABB_CCDD; l0 = ld_n;
    ldq.push_back('{32'h0000_1000, 3'd2, 32'd0});
    wait_mc("t2_grant", 10);
    chk("t2_mc_len", bus.mc_len, 2);
    chk("t2_mc_wr", bus.mc_wr, 0);
    chk("t2_mc_addr", bus.mc_addr, 32'h0000_1000);
    chk("t2_mc_data", bus.mc_data, 0);
    drain("t2_drain", 50);
    chk("t2_ld_acks", ld_n - l0, 1);
    chk("t2_ld_data", bus.ld_data, 32'h0000_CCDD);
    // simultaneous store, load, fetch
    lat = 1; rd_fix_en = 1'b0; b = glog.size(); s0 = st_n; l0 = ld_n; i0 = if_n;
    stq.push_back('{32'h0000_8010, 3'd4, 32'h5566_7788});
    ldq.push_back('{32'h0000_1004, 3'd1, 32'd0});
    ifq.push_back(32'h0000_4000);
    drain("t3_drain", 60);
    chk("t3_grant0", glog[b], 32'h0000_8010);
    chk("t3_grant1", glog[b+1], 32'h0000_1004);
    chk("t3_grant2", glog[b+2], 32'h0000_4000);
    chk("t3_gap01", gcyc[b+1] - gcyc[b], 3);
    chk("t3_gap12", gcyc[b+2] - gcyc[b+1], 3);
    chk("t3_acks", {8'(st_n - s0), 8'(ld_n - l0), 8'(if_n - i0)}, 24'h010101);
    chk("t3_ld_data", bus.ld_data, 32'h0000_00FB);
    chk("t3_if_data", bus.if_data, 32'h4000_BFFF);
    // fetch starvation guard
    b = glog.size();
    for (int i = 0; i < 5; i++) stq.push_back('{32'h0000_8100 + 32'(16 * i), 3'd4, 32'h0101_0101 * 32'(i + 1)});
    for (int i = 1; i <= 5; i++) ldq.push_back('{32'h0000_1000 + 32'(16 * i), 3'd2, 32'd0});
    ifq.push_back(32'h0000_4100);
    n = 0;
    while (!(bus.mc_req && bus.mc_addr == 32'h0000_4100) && n < 100) begin @(posedge clk); #2; n++; end
    chk("t4_fetch_seen", n < 100, 1);
    chk("t4_starve_clr", 32'(dut.starve_q), 0);
    drain("t4_drain", 100);
    chk("t4_grants", glog.size() - b, 11);
    chk("t4_grant8", glog[b+7], 32'h0000_1030);
    chk("t4_grant9", glog[b+8], 32'h0000_4100);
    chk("t4_grant10", glog[b+9], 32'h0000_1040);
    chk("t4_ld_data", bus.ld_data, 32'h0000_EFAF);
    // flush during a load, store waiting
    lat = 4; b = glog.size(); l0 = ld_n; s0 = st_n;
    ldq.push_back('{32'h0000_2000, 3'd4, 32'd0});
    wait_mc("t5_grant", 10);
    flush_n++;
    stq.push_back('{32'h0000_8200, 3'd2, 32'hCAFE_BABE});
    drain("t5_drain", 60);
    chk("t5_ld_acks", ld_n - l0, 0);
    chk("t5_st_acks", st_n - s0, 1);
    chk("t5_ld_data", bus.ld_data, 32'h0000_EFAF);
    chk("t5_grant0", glog[b], 32'h0000_2000);
    chk("t5_grant1", glog[b+1], 32'h0000_8200);
    chk("t5_gap", gcyc[b+1] - gcyc[b], 6);
    // rdy low while the controller pulses done
    lat = 2; rd_fix_en = 1'b1; rd_fix = 32'h1234_5678; l0 = ld_n;
    stall_n++;
    ldq.push_back('{32'h0000_1060, 3'd4, 32'd0});
    wait_mc("t6_grant", 10);
    repeat (3) begin
      @(posedge clk); #2;
      chk("t6_hold_req", bus.mc_req, 1);
      chk("t6_hold_ack", bus.ld_ack, 0);
    end
    drain("t6_drain", 60);
    chk("t6_ld_acks", ld_n - l0, 1);
    chk("t6_ld_data", bus.ld_data, 32'h1234_5678);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog actual=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Arbitration and sequencing front-end for the byte-serial memory controller. Shares the single controller request port between three requesters: ICache miss fetch, LSB load, and ROB-committed store. One transaction is outstanding at a time. Fixed priority store > load > fetch, with a starvation guard for fetch and speculative-flush cancellation of loads and fetches. It sits between ICache/LSB and the memory controller and routes each completion back to its owner.

## Interface
- STARVE_MAX, 8: consecutive data grants tolerated while `if_req` is pending before fetch is forced.
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- rdy  in  1  global enable; low freezes the block
- flush  in  1  speculation clear (branch mispredict)
- if_req  in  1  fetch request; held with `if_addr` until `if_ack`
- if_addr  in  32  fetch address; length is always 4
- if_ack  out  1  one-cycle completion pulse
- if_data  out  32  fetched word, valid with `if_ack`
- ld_req  in  1  load request; held with addr/len until `ld_ack`
- ld_addr  in  32  load address
- ld_len  in  3  byte count; legal values 1, 2, 4
- ld_ack  out  1  one-cycle completion pulse
- ld_data  out  32  load data, zero above `ld_len` bytes
- st_req  in  1  store request; held with addr/len/data until `st_ack`
- st_addr  in  32  store address
- st_len  in  3  byte count; legal values 1, 2, 4
- st_data  in  32  store data, little-endian
- st_ack  out  1  one-cycle completion pulse
- mc_req  out  1  request to controller; held until `mc_done` is sampled
- mc_wr  out  1  1 = store, 0 = read
- mc_addr  out  32  transaction address
- mc_len  out  3  transaction byte count
- mc_data  out  32  store data; 0 for reads
- mc_done  in  1  controller completion pulse
- mc_rdata  in  32  read data, valid with `mc_done`

## Operation
- States:
  - IDLE: sample requests and grant.
  - BUSY: `mc_req` high, waiting for `mc_done`.
  - RESP: ack pulse cycle; no sampling.
- Grant in IDLE, evaluated at the rising edge:
  - If `flush` is high, `ld_req` and `if_req` are ignored for that edge. `st_req` may still be granted.
  - If `if_req` is high and `starve_cnt == STARVE_MAX`, grant fetch.
  - Otherwise grant `st_req`, else `ld_req`, else `if_req`.
  - On a grant, latch owner, `mc_wr`, `mc_addr`, `mc_len` (4 for fetch), and `mc_data` (0 unless store). Then go to BUSY.
- starve_cnt:
  - Width is clog2(STARVE_MAX+1).
  - A store or load grant with `if_req` high increments it, saturating at STARVE_MAX.
  - A fetch grant, or a data grant with `if_req` low, clears it to 0.
- BUSY:
  - `mc_req` and all `mc_*` fields stay stable.
  - On `mc_done`, capture `mc_rdata` into the owner's data register, drop `mc_req`, and go to RESP.
  - In the RESP cycle, the owner's ack is high unless the cancel flag is set.
- Load data masking: len 1 keeps [7:0]; len 2 keeps [15:0]; len 4 keeps all bits. All other bits are 0.
- Flush cancellation:
  - `flush` sampled during BUSY with a load or fetch owner sets the cancel flag.
  - The transaction still runs to `mc_done`, because the controller cannot abort mid-stream.
  - Its ack is suppressed and its data register is not updated.
  - Stores are never cancelled.
  - `flush` during RESP does not retract an ack already high.
- RESP -> IDLE unconditionally. The cancel flag clears on entering IDLE.
- `rdy` low: state, counter, cancel flag and all outputs hold. `mc_done` is not sampled.
- Illegal len (0, 3, 5-7): forwarded unchanged; behaviour is undefined. Benches must not drive it.

## Timing
- Reset values (async assert, takes effect immediately):
  - state IDLE, starve_cnt 0, cancel 0.
  - `mc_req`, `mc_wr`, `if_ack`, `ld_ack`, `st_ack` = 0.
  - `mc_addr`, `mc_len`, `mc_data`, `if_data`, `ld_data` = 0.
- Reset mid-BUSY abandons the transaction. The controller shares `rst` and resets with it.
- Edge sequence: request sampled at edge E0 -> `mc_req` high after E0. `mc_done` sampled at E1 -> ack high during [E1, E2). IDLE from E2. Earliest next grant at E3.
- Request-to-ack latency = controller latency + 1 cycle.
- Requesters drop `req` at the edge ending their ack cycle. RESP guarantees a re-grant is never issued on a stale `req`.
- At most one ack is high per cycle. Acks are never asserted outside RESP.

## Test plan
- Reset mid-BUSY: assert `rst` asynchronously -> all outputs 0 immediately. After release, `st_req` is granted on the first edge.
- Single load: `ld_addr` 0x1000, len 2; controller returns `mc_rdata` 0xAABBCCDD after 2 cycles -> `ld_ack` for exactly 1 cycle, `ld_data` 0x0000CCDD, `mc_len` 2, `mc_wr` 0.
- Simultaneous store, load and fetch: grant order store, load, fetch. Each `mc_req` is separated by a 1-cycle RESP plus a 1-cycle IDLE. Acks never overlap.
- Starvation with STARVE_MAX 8: `if_req` held while loads and stores are continuously offered -> fetch granted as the 9th grant; starve_cnt then reads 0.
- Flush mid-load: assert `flush` for 1 cycle during BUSY -> `mc_req` held until `mc_done`, `ld_ack` never pulses, `ld_data` unchanged. A pending store is granted next.
- `rdy` low for 3 cycles during BUSY with `mc_done` pulsing -> no state change and outputs held. Completion occurs only after `rdy` returns and `mc_done` is sampled.
